// File: rtl/gpio_input_capture_pkg.sv
// Shared definitions for the GPIO input-capture register bank.
// The decoder and firmware headers use these register addresses.
package gpio_input_capture_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA    = 2'd0;
  localparam reg_addr_t ADDR_STATUS  = 2'd1;
  localparam reg_addr_t ADDR_RISE_EN = 2'd2;
  localparam reg_addr_t ADDR_FALL_EN = 2'd3;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/gpio_input_capture_if.sv
// CPU-side register bus of the GPIO input-capture block.
// The address decoder drives the master side; the peripheral is the slave.
interface gpio_input_capture_if #(
  parameter int WIDTH = 32
);

  logic             we;
  logic             re;
  logic [1:0]       addr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output we, re, addr, data_in,
    input  data_out
  );

  modport slave (
    input  we, re, addr, data_in,
    output data_out
  );

endinterface

// File: rtl/gpio_in_debounce.sv
// One-bit pin conditioner: 2-flop synchroniser followed by a stability counter.
// The debounced output only moves after DEBOUNCE_CYCLES consecutive differing samples.
module gpio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so each flop samples pre-edge values; the synchroniser chain relies on it.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/gpio_input_capture.sv
// Input GPIO peripheral: per-pin debounce, enabled edge capture into sticky W1C
// status flags, level interrupt, and a combinational register read mux.
module gpio_input_capture
  import gpio_input_capture_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_input_capture_if.slave  bus,
  input  logic [WIDTH-1:0]     gpio_in,
  output logic                 irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] rise_en_d;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] fall_en_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rd_data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .pin_i (gpio_in[i]),
      .deb_o (deb[i])
    );
  end

  assign edge_set = (deb & ~deb_dly_q & rise_en_q) | (~deb & deb_dly_q & fall_en_q);

  always_comb begin
    w1c_mask  = '0;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (bus.we) begin
      case (bus.addr)
        ADDR_STATUS:  w1c_mask  = bus.data_in;
        ADDR_RISE_EN: rise_en_d = bus.data_in;
        ADDR_FALL_EN: fall_en_d = bus.data_in;
        default:      ;
      endcase
    end
    // Set is OR-ed after the clear so a same-cycle edge survives a W1C.
    status_d = (status_q & ~w1c_mask) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_dly_q <= '0;
      status_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      deb_dly_q <= deb;
      status_q  <= status_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.re) begin
      case (bus.addr)
        ADDR_DATA:    rd_data = deb;
        ADDR_STATUS:  rd_data = status_q;
        ADDR_RISE_EN: rd_data = rise_en_q;
        ADDR_FALL_EN: rd_data = fall_en_q;
        default:      rd_data = '0;
      endcase
    end
  end

  assign bus.data_out = rd_data;
  assign irq          = |status_q;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture: debounce latency, bounce restart,
// edge capture, W1C, set-vs-clear collision and mid-run reset.
module tb_gpio_input_capture;
  import gpio_input_capture_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] gpio_in;
  logic         irq;
  logic [W-1:0] rd;

  int n_checks;
  int n_fail;

  gpio_input_capture_if #(.WIDTH(W)) bus ();

  gpio_input_capture #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input reg_addr_t a, input logic [W-1:0] d);
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    tick(1);
    bus.we      = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic bus_read(input reg_addr_t a, output logic [W-1:0] d);
    bus.re   = 1'b1;
    bus.addr = a;
    #1;
    d        = bus.data_out;
    bus.re   = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    gpio_in = '0;
    tick(2);
    reset   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.addr    = ADDR_DATA;
    bus.data_in = '0;
    gpio_in     = '0;
    reset       = 1'b1;
    #1;

    // 1: reset state
    do_reset();
    bus_read(ADDR_DATA, rd);    check("rst_data", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("rst_status", rd, 32'h0);
    bus_read(ADDR_RISE_EN, rd); check("rst_rise_en", rd, 32'h0);
    bus_read(ADDR_FALL_EN, rd); check("rst_fall_en", rd, 32'h0);
    check("rst_irq", W'(irq), 32'h0);

    // Enable registers read back; re low forces zero; DATA is read-only
    bus_write(ADDR_RISE_EN, 32'hA5A5_0001);
    bus_read(ADDR_RISE_EN, rd); check("rise_en_rb", rd, 32'hA5A5_0001);
    bus.addr = ADDR_RISE_EN; #1;
    check("re_low_zero", bus.data_out, 32'h0);
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, rd);    check("data_ro", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("data_ro_status", rd, 32'h0);

    // 2: rising edge on bit0, latency 6 to DATA and 7 to STATUS; fall disabled
    do_reset();
    bus_write(ADDR_RISE_EN, 32'h1);
    gpio_in[0] = 1'b1;
    tick(5);
    bus_read(ADDR_DATA, rd);    check("rise_data_e5", rd, 32'h0);
    tick(1);
    bus_read(ADDR_DATA, rd);    check("rise_data_e6", rd, 32'h1);
    bus_read(ADDR_STATUS, rd);  check("rise_status_e6", rd, 32'h0);
    check("rise_irq_e6", W'(irq), 32'h0);
    tick(1);
    bus_read(ADDR_STATUS, rd);  check("rise_status_e7", rd, 32'h1);
    check("rise_irq_e7", W'(irq), 32'h1);
    bus_write(ADDR_STATUS, 32'h1);
    gpio_in[0] = 1'b0;
    tick(8);
    bus_read(ADDR_DATA, rd);    check("fall_data", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("fall_disabled", rd, 32'h0);

    // 3: bounce on bit3 restarts the count
    do_reset();
    bus_write(ADDR_RISE_EN, 32'h8);
    bus_write(ADDR_FALL_EN, 32'h8);
    gpio_in[3] = 1'b1; tick(3);
    gpio_in[3] = 1'b0; tick(1);
    gpio_in[3] = 1'b1;
    tick(5);
    bus_read(ADDR_DATA, rd);    check("bounce_data_e5", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("bounce_status_e5", rd, 32'h0);
    tick(1);
    bus_read(ADDR_DATA, rd);    check("bounce_data_e6", rd, 32'h8);
    tick(1);
    bus_read(ADDR_STATUS, rd);  check("bounce_status_e7", rd, 32'h8);
    bus_write(ADDR_STATUS, 32'h8);
    tick(2);
    bus_read(ADDR_STATUS, rd);  check("bounce_single_set", rd, 32'h0);
    gpio_in[3] = 1'b0;
    tick(7);
    bus_read(ADDR_DATA, rd);    check("bounce_fall_data", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("bounce_fall_status", rd, 32'h8);

    // 4: W1C on a two-bit status, plus read-during-write returns old value
    do_reset();
    bus_write(ADDR_RISE_EN, 32'h5);
    gpio_in = 32'h5;
    tick(7);
    bus_read(ADDR_STATUS, rd);  check("w1c_pre", rd, 32'h5);
    bus.we      = 1'b1;
    bus.re      = 1'b1;
    bus.addr    = ADDR_STATUS;
    bus.data_in = 32'h4;
    #1;
    check("rw_same_cycle", bus.data_out, 32'h5);
    tick(1);
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus_read(ADDR_STATUS, rd);  check("w1c_bit2", rd, 32'h1);
    check("w1c_irq_on", W'(irq), 32'h1);
    bus_write(ADDR_STATUS, 32'h1);
    bus_read(ADDR_STATUS, rd);  check("w1c_bit0", rd, 32'h0);
    check("w1c_irq_off", W'(irq), 32'h0);
    bus_read(ADDR_DATA, rd);    check("w1c_no_data_effect", rd, 32'h5);

    // 5: set wins over a same-edge W1C
    do_reset();
    bus_write(ADDR_RISE_EN, 32'h1);
    gpio_in[0] = 1'b1;
    tick(5);
    bus_write(ADDR_STATUS, 32'h1);
    bus_read(ADDR_STATUS, rd);  check("collide_pre", rd, 32'h0);
    bus_write(ADDR_STATUS, 32'h1);
    bus_read(ADDR_STATUS, rd);  check("collide_set_wins", rd, 32'h1);
    bus_write(ADDR_STATUS, 32'h1);
    bus_read(ADDR_STATUS, rd);  check("collide_then_clear", rd, 32'h0);

    // 6: mid-operation reset with the pin held high
    do_reset();
    bus_write(ADDR_RISE_EN, 32'h1);
    gpio_in[0] = 1'b1;
    tick(7);
    bus_read(ADDR_STATUS, rd);  check("mrst_pre", rd, 32'h1);
    gpio_in[0] = 1'b0;
    tick(3);
    gpio_in[0] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus_read(ADDR_DATA, rd);    check("mrst_data", rd, 32'h0);
    bus_read(ADDR_STATUS, rd);  check("mrst_status", rd, 32'h0);
    bus_read(ADDR_RISE_EN, rd); check("mrst_rise_en", rd, 32'h0);
    check("mrst_irq", W'(irq), 32'h0);
    bus_write(ADDR_RISE_EN, 32'h1);
    tick(4);
    bus_read(ADDR_DATA, rd);    check("mrst_requal_e5", rd, 32'h0);
    tick(1);
    bus_read(ADDR_DATA, rd);    check("mrst_requal_e6", rd, 32'h1);
    tick(1);
    bus_read(ADDR_STATUS, rd);  check("mrst_status_again", rd, 32'h1);
    check("mrst_irq_again", W'(irq), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
